// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block: register addresses,
// status bit positions and the address decoder.
package mmio_io_ctrl_pkg;

  localparam logic [31:0] MMIO_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
  localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST      = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_RST   = 32'h8000_0018;

  localparam int STAT_TX_READY    = 0;
  localparam int STAT_RX_NONEMPTY = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_RX,
    REG_TX,
    REG_CYCLE,
    REG_INST,
    REG_CNT_RST
  } reg_sel_e;

  // Full 32-bit match: aliases and unaligned addresses are not mapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    case (addr)
      MMIO_UART_CTRL: decode_addr = REG_CTRL;
      MMIO_UART_RX:   decode_addr = REG_RX;
      MMIO_UART_TX:   decode_addr = REG_TX;
      MMIO_CYCLE:     decode_addr = REG_CYCLE;
      MMIO_INST:      decode_addr = REG_INST;
      MMIO_CNT_RST:   decode_addr = REG_CNT_RST;
      default:        decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_rx_fifo.sv
// Small byte FIFO for UART receive data. Pointers wrap naturally; a separate
// occupancy count tells full from empty. Push is accepted when full if a pop happens too.
module io_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count and pointers alone
  // define which entries are valid, so the array stays a plain register file.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-stage MMIO controller: address decode, UART TX holding register,
// RX byte FIFO, cycle/instruction counters and a registered read port.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_re,
  input  logic        io_we,
  input  logic        inst_retire,
  output logic        io_hit,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  reg_sel_e         sel;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       rx_head;
  logic             rx_push;
  logic             rx_pop;
  logic             tx_handshake;
  logic             tx_accept;
  logic             cnt_clr;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign sel           = decode_addr(io_addr);
  assign io_hit        = (sel != REG_NONE);
  assign uart_rx_ready = !fifo_full;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = io_re && (sel == REG_RX);
  assign tx_handshake  = uart_tx_valid && uart_tx_ready;
  // A store in the handshake cycle refills the holding register seamlessly.
  assign tx_accept     = io_we && (sel == REG_TX) && (!uart_tx_valid || tx_handshake);
  assign cnt_clr       = io_we && (sel == REG_CNT_RST);
  assign unused_wdata  = ^io_wdata[31:8];

  io_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_rx_data),
    .head  (rx_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: rd_mux gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL: begin
        rd_mux[STAT_TX_READY]    = !uart_tx_valid;
        rd_mux[STAT_RX_NONEMPTY] = !fifo_empty;
      end
      REG_RX:    if (!fifo_empty) rd_mux[7:0] = rx_head;
      REG_CYCLE: rd_mux = 32'(cycle_cnt);
      REG_INST:  rd_mux = 32'(inst_cnt);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_rdata      <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      cycle_cnt     <= '0;
      inst_cnt      <= '0;
    end else begin
      if (io_re && io_hit) io_rdata <= rd_mux;

      if (tx_accept) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= io_wdata[7:0];
      end else if (tx_handshake) begin
        uart_tx_valid <= 1'b0;
      end

      if (cnt_clr) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        inst_cnt  <= inst_cnt + CNT_W'(inst_retire);
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: a queue-based reference model runs in
// lockstep, plus directed sequences and a decode/read table after reset.
module tb_mmio_io_ctrl;
  import mmio_io_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_re;
  logic        io_we;
  logic        inst_retire;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;

  logic        io_hit,  io_hit8;
  logic [31:0] io_rdata, io_rdata8;
  logic [7:0]  uart_tx_data, tx_data8;
  logic        uart_tx_valid, tx_valid8;
  logic        uart_rx_ready, rx_ready8;

  always #5 clk = ~clk;

  mmio_io_ctrl #(.RX_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_re(io_re), .io_we(io_we), .inst_retire(inst_retire),
    .io_hit(io_hit), .io_rdata(io_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  // Narrow-counter instance so counter wrap is reachable in a short run.
  mmio_io_ctrl #(.RX_DEPTH(DEPTH), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_re(io_re), .io_we(io_we), .inst_retire(inst_retire),
    .io_hit(io_hit8), .io_rdata(io_rdata8),
    .uart_tx_data(tx_data8), .uart_tx_valid(tx_valid8), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rx_ready8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit [7:0]  m_q[$];
  bit        m_tx_v;
  bit [7:0]  m_tx_d;
  bit [31:0] m_cyc, m_inst;
  bit [31:0] m_rdata, m_rdata8;

  function automatic bit is_mapped(input logic [31:0] a);
    return a inside {MMIO_UART_CTRL, MMIO_UART_RX, MMIO_UART_TX,
                     MMIO_CYCLE, MMIO_INST, MMIO_CNT_RST};
  endfunction

  task automatic model_step();
    bit [31:0] v, v8;
    int  n;
    bit  hs, st;
    if (!rst_n) begin
      m_q.delete();
      m_tx_v = 0; m_tx_d = 0; m_cyc = 0; m_inst = 0; m_rdata = 0; m_rdata8 = 0;
    end else begin
      n = m_q.size();
      v = 0;
      if (io_addr == MMIO_UART_CTRL) v = {30'b0, n != 0, !m_tx_v};
      if (io_addr == MMIO_UART_RX && n > 0) v = {24'b0, m_q[0]};
      if (io_addr == MMIO_CYCLE) v = m_cyc;
      if (io_addr == MMIO_INST)  v = m_inst;
      v8 = v;
      if (io_addr == MMIO_CYCLE) v8 = {24'b0, m_cyc[7:0]};
      if (io_addr == MMIO_INST)  v8 = {24'b0, m_inst[7:0]};
      if (io_re && is_mapped(io_addr)) begin
        m_rdata = v; m_rdata8 = v8;
      end
      if (io_re && io_addr == MMIO_UART_RX && n > 0) void'(m_q.pop_front());
      if (uart_rx_valid && n < DEPTH) m_q.push_back(uart_rx_data);
      hs = m_tx_v && uart_tx_ready;
      st = io_we && io_addr == MMIO_UART_TX;
      if (st && (!m_tx_v || hs)) begin
        m_tx_v = 1; m_tx_d = io_wdata[7:0];
      end else if (hs) begin
        m_tx_v = 0;
      end
      if (io_we && io_addr == MMIO_CNT_RST) begin
        m_cyc = 0; m_inst = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + 32'(inst_retire);
      end
    end
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("io_rdata", io_rdata, m_rdata);
    check("io_rdata_cnt8", io_rdata8, m_rdata8);
    check("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_tx_v});
    check("tx_data", {24'b0, uart_tx_data}, {24'b0, m_tx_d});
    check("rx_ready", {31'b0, uart_rx_ready}, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
    check("tx_valid_cnt8", {31'b0, tx_valid8}, {31'b0, m_tx_v});
  endtask

  task automatic op(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    io_re = re; io_we = we; io_addr = addr; io_wdata = wdata;
    #1;
    check("io_hit", {31'b0, io_hit}, {31'b0, is_mapped(addr)});
    tick();
    io_re = 1'b0; io_we = 1'b0;
  endtask

  task automatic op_rd(input logic [31:0] addr);
    op(1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic op_wr(input logic [31:0] addr, input logic [31:0] wdata);
    op(1'b0, 1'b1, addr, wdata);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t vec[12];
  logic [31:0] rand_addr[9];

  initial begin
    vec[0]  = '{MMIO_UART_CTRL, 1'b1, 32'h1};
    vec[1]  = '{32'h8000_0020,  1'b0, 32'h1};
    vec[2]  = '{32'h0000_0000,  1'b0, 32'h1};
    vec[3]  = '{32'h8000_0001,  1'b0, 32'h1};
    vec[4]  = '{MMIO_UART_RX,   1'b1, 32'h0};
    vec[5]  = '{MMIO_INST,      1'b1, 32'h0};
    vec[6]  = '{MMIO_UART_CTRL, 1'b1, 32'h1};
    vec[7]  = '{MMIO_UART_TX,   1'b1, 32'h0};
    vec[8]  = '{32'hFFFF_FFFF,  1'b0, 32'h0};
    vec[9]  = '{MMIO_UART_CTRL, 1'b1, 32'h1};
    vec[10] = '{MMIO_CNT_RST,   1'b1, 32'h0};
    vec[11] = '{32'h8000_001C,  1'b0, 32'h0};

    rand_addr = '{MMIO_UART_CTRL, MMIO_UART_RX, MMIO_UART_TX, MMIO_CYCLE,
                  MMIO_INST, MMIO_CNT_RST, 32'h8000_0020, 32'h0000_0004, 32'h8000_000C};

    rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_re = 1'b0; io_we = 1'b0;
    inst_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);

    // Decode and idle-state reads from the table
    for (int i = 0; i < 12; i++) begin
      io_re = 1'b1; io_addr = vec[i].addr;
      #1;
      check("tbl_hit", {31'b0, io_hit}, {31'b0, vec[i].hit});
      tick();
      io_re = 1'b0;
      check("tbl_rdata", io_rdata, vec[i].rdata);
    end

    // TX: stall three cycles, dropped second store, then handshake
    uart_tx_ready = 1'b0;
    op_wr(MMIO_UART_TX, 32'hABCD_EF41);
    for (int i = 0; i < 3; i++) begin
      check("tx_hold_valid", {31'b0, uart_tx_valid}, 32'h1);
      check("tx_hold_data", {24'b0, uart_tx_data}, 32'h41);
      if (i == 1) op_wr(MMIO_UART_TX, 32'h42);
      else tick();
    end
    uart_tx_ready = 1'b1;
    check("tx_hs_data", {24'b0, uart_tx_data}, 32'h41);
    tick();
    uart_tx_ready = 1'b0;
    check("tx_after_hs", {31'b0, uart_tx_valid}, 32'h0);
    op_rd(MMIO_UART_CTRL);
    check("tx_ready_status", io_rdata, 32'h1);
    op_wr(MMIO_UART_TX, 32'h50);
    uart_tx_ready = 1'b1;
    op_wr(MMIO_UART_TX, 32'h51);
    check("tx_hs_store_valid", {31'b0, uart_tx_valid}, 32'h1);
    check("tx_hs_store_data", {24'b0, uart_tx_data}, 32'h51);
    tick();
    uart_tx_ready = 1'b0;
    check("tx_drain", {31'b0, uart_tx_valid}, 32'h0);

    // RX: fill, overflow held off, drain in order, empty read
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'(17 * (i + 1));
      tick();
    end
    check("rx_full_ready", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_data = 8'h55;
    tick(); tick();
    uart_rx_valid = 1'b0;
    op_rd(MMIO_UART_CTRL);
    check("rx_status", io_rdata, 32'h3);
    for (int i = 0; i < 4; i++) begin
      op_rd(MMIO_UART_RX);
      check("rx_order", io_rdata, 32'(17 * (i + 1)));
    end
    op_rd(MMIO_UART_RX);
    check("rx_empty_read", io_rdata, 32'h0);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h66;
    tick();
    uart_rx_valid = 1'b0;
    op_rd(MMIO_UART_RX);
    check("rx_after_empty", io_rdata, 32'h66);

    // RX: full FIFO with pop and pending byte, then push+pop at count 3
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'hA1 + 8'(i);
      tick();
    end
    uart_rx_data = 8'hB5;
    op_rd(MMIO_UART_RX);
    check("full_pop_head", io_rdata, 32'hA1);
    check("full_pop_ready", {31'b0, uart_rx_ready}, 32'h1);
    tick();
    check("refill_ready", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_valid = 1'b0;
    op_rd(MMIO_UART_RX);
    check("pop_a2", io_rdata, 32'hA2);
    uart_rx_valid = 1'b1; uart_rx_data = 8'hC6;
    op_rd(MMIO_UART_RX);
    uart_rx_valid = 1'b0;
    check("pushpop_head", io_rdata, 32'hA3);
    check("pushpop_ready", {31'b0, uart_rx_ready}, 32'h1);
    op_rd(MMIO_UART_RX); check("drain_a4", io_rdata, 32'hA4);
    op_rd(MMIO_UART_RX); check("drain_b5", io_rdata, 32'hB5);
    op_rd(MMIO_UART_RX); check("drain_c6", io_rdata, 32'hC6);
    op_rd(MMIO_UART_RX); check("drain_empty", io_rdata, 32'h0);

    // Counters: 100 cycles with 37 retires, then clear coincident with retire
    op_wr(MMIO_CNT_RST, 32'hDEAD_BEEF);
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0) && (i < 74);
      tick();
    end
    inst_retire = 1'b0;
    op_rd(MMIO_CYCLE); check("cycle_100", io_rdata, 32'd100);
    op_rd(MMIO_INST);  check("inst_37", io_rdata, 32'd37);
    inst_retire = 1'b1;
    op_wr(MMIO_CNT_RST, 32'h0);
    inst_retire = 1'b0;
    op_rd(MMIO_CYCLE); check("clr_cycle", io_rdata, 32'd0);
    op_rd(MMIO_INST);  check("clr_inst", io_rdata, 32'd0);
    op_rd(MMIO_CYCLE); check("cycle_pre_edge", io_rdata, 32'd2);

    // Counter wrap on the 8-bit instance; unmapped load leaves read data alone
    op_wr(MMIO_CNT_RST, 32'h0);
    repeat (255) tick();
    op_rd(MMIO_CYCLE);
    check("wrap_pre32", io_rdata, 32'd255);
    check("wrap_pre8", io_rdata8, 32'd255);
    op_rd(MMIO_CYCLE);
    check("wrap_post32", io_rdata, 32'd256);
    check("wrap_post8", io_rdata8, 32'd0);
    io_addr = 32'h8000_0020;
    #1;
    check("unmapped_hit", {31'b0, io_hit}, 32'h0);
    op_rd(32'h8000_0020);
    check("unmapped_rdata", io_rdata, 32'd256);

    // Reset while a TX byte is pending and the FIFO holds data
    op_wr(MMIO_UART_TX, 32'h77);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    tick(); tick();
    uart_rx_valid = 1'b0;
    op_rd(MMIO_UART_CTRL);
    check("pre_rst_status", io_rdata, 32'h2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("mid_rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("mid_rst_rdata", io_rdata, 32'h0);
    op_rd(MMIO_UART_CTRL); check("post_rst_status", io_rdata, 32'h1);
    op_rd(MMIO_UART_RX);   check("post_rst_rx", io_rdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [31:0] a;
      a = rand_addr[$urandom_range(0, 8)];
      kind = $urandom_range(0, 3);
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_rx_data  = 8'($urandom);
      uart_tx_ready = ($urandom_range(0, 3) == 0);
      inst_retire   = 1'($urandom_range(0, 1));
      if (kind == 1 || kind == 3) op_rd(a);
      else if (kind == 2)         op_wr(a, $urandom);
      else                        tick();
    end
    uart_rx_valid = 1'b0; uart_tx_ready = 1'b0; inst_retire = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
